// File: rtl/sap_out_display.sv
// SAP-1 output display: serial double-dabble binary-to-BCD conversion of the
// output register, time-multiplexed onto a 3-digit active-low 7-segment display.
module sap_out_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  resultado,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [2:0]  an
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  sr_q, sr_d;
    logic [11:0] scr_q, scr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  an_q, an_d;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0: decode = 7'b1000000;
            4'd1: decode = 7'b1111001;
            4'd2: decode = 7'b0100100;
            4'd3: decode = 7'b0110000;
            4'd4: decode = 7'b0011001;
            4'd5: decode = 7'b0010010;
            4'd6: decode = 7'b0000010;
            4'd7: decode = 7'b1111000;
            4'd8: decode = 7'b0000000;
            4'd9: decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 8'h00;
            sr_q    <= 8'h00;
            scr_q   <= 12'h000;
            cnt_q   <= 3'd0;
            bcd_q   <= 12'h000;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'b1000000;
            an_q    <= 3'b110;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    always_comb begin
        logic [11:0] adj;
        state_d = state_q;
        last_d  = last_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        adj     = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};
        case (state_q)
            IDLE: if (resultado != last_q) begin
                last_d  = resultado;
                sr_d    = resultado;
                scr_d   = 12'h000;
                cnt_d   = 3'd0;
                busy_d  = 1'b1;
                state_d = CONV;
            end
            CONV: begin
                {scr_d, sr_d} = {adj, sr_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = scr_d;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Display is driven from next-state values so seg/an always match idx_q/bcd_q.
    always_comb begin
        logic [3:0] nib;
        logic       blank;
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PMAX) begin
            pre_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        case (idx_d)
            2'd1:    nib = bcd_d[7:4];
            2'd2:    nib = bcd_d[11:8];
            default: nib = bcd_d[3:0];
        endcase
        blank = BLANK_LZ && (((idx_d == 2'd2) && (bcd_d[11:8] == 4'd0)) ||
                             ((idx_d == 2'd1) && (bcd_d[11:4] == 8'd0)));
        seg_d = blank ? 7'b1111111 : decode(nib);
        an_d  = ~(3'b001 << idx_d);
    end

    always_comb begin
        bcd  = bcd_q;
        busy = busy_q;
        seg  = seg_q;
        an   = an_q;
    end
endmodule

// File: tb/tb_sap_out_display.sv
// Scoreboard bench for sap_out_display: randomized and directed input values,
// decimal reference model, independent display-position model.
module tb_sap_out_display;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  resultado;
    logic [11:0] bcd_a, bcd_b;
    logic        busy_a, busy_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  an_a, an_b;

    int checks = 0;
    int errors = 0;
    int n;
    int prev;
    logic [11:0] sbq[$];

    always #5 clock = ~clock;

    sap_out_display #(.REFRESH_DIV(3), .BLANK_LZ(1'b1)) dut_a (
        .clock(clock), .reset(reset), .resultado(resultado),
        .bcd(bcd_a), .busy(busy_a), .seg(seg_a), .an(an_a));

    sap_out_display #(.REFRESH_DIV(1), .BLANK_LZ(1'b0)) dut_b (
        .clock(clock), .reset(reset), .resultado(resultado),
        .bcd(bcd_b), .busy(busy_b), .seg(seg_b), .an(an_b));

    // Edges since reset release; digit position is (n / REFRESH_DIV) mod 3.
    always @(posedge clock or posedge reset)
        if (reset) n <= 0;
        else       n <= n + 1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blz);
        logic [6:0] tbl [0:9];
        int h, t, o, d;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        h = v / 100; t = (v / 10) % 10; o = v % 10;
        d = (pos == 0) ? o : (pos == 1) ? t : h;
        if (blz && ((pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0)))
            return 7'b1111111;
        return tbl[d];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int v);
        resultado = 8'(v);
        if (v != prev) sbq.push_back(to_bcd(v));
        prev = v;
    endtask

    task automatic check_disp(input int v, input int ncy);
        repeat (ncy) begin
            @(negedge clock);
            chk("seg_a", int'(seg_a), int'(exp_seg(v, (n / 3) % 3, 1'b1)));
            chk("an_a", int'(an_a), int'(~(3'b001 << ((n / 3) % 3))) & 7);
            chk("seg_b", int'(seg_b), int'(exp_seg(v, n % 3, 1'b0)));
            chk("an_b", int'(an_b), int'(~(3'b001 << (n % 3))) & 7);
        end
    endtask

    // Monitor: each falling busy edge presents one completed conversion.
    initial begin
        int  blen;
        bit  bprev;
        logic [11:0] e;
        blen = 0; bprev = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                blen = 0; bprev = 0;
            end else begin
                if (busy_a) blen++;
                if (!busy_a && bprev) begin
                    if (sbq.size() == 0) chk("unexpected_conv", 1, 0);
                    else begin
                        e = sbq.pop_front();
                        chk("bcd_a", int'(bcd_a), int'(e));
                        chk("bcd_b", int'(bcd_b), int'(e));
                        chk("busy_len", blen, 8);
                    end
                    blen = 0;
                end
                bprev = busy_a;
            end
        end
    end

    initial begin
        int v;
        reset = 1'b1; resultado = 8'd0; prev = 0;
        #2;
        chk("rst_bcd", int'(bcd_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_an", int'(an_a), 3'b110);
        chk("rst_seg", int'(seg_a), 7'b1000000);
        chk("rst_seg_b", int'(seg_b), 7'b1000000);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Zero held: no conversion, leading zeros blank on dut_a.
        repeat (10) begin
            @(negedge clock);
            chk("zero_busy", int'(busy_a), 0);
        end
        check_disp(0, 6);

        // Reset in the 4th conversion cycle of 200.
        @(negedge clock);
        resultado = 8'd200;
        @(posedge clock);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_bcd", int'(bcd_a), 0);
        @(negedge clock);
        @(negedge clock);
        sbq.push_back(to_bcd(200));
        prev = 200;
        reset = 1'b0;
        repeat (9) @(posedge clock);
        #1 chk("midrst_200", int'(bcd_a), 12'h200);
        repeat (4) @(negedge clock);
        check_disp(200, 6);

        // 255: exact completion edge.
        @(negedge clock);
        drive(255);
        @(posedge clock);
        repeat (7) @(posedge clock);
        #1 chk("k7_busy", int'(busy_a), 1);
        @(posedge clock);
        #1;
        chk("k8_bcd", int'(bcd_a), 12'h255);
        chk("k8_busy", int'(busy_a), 0);
        repeat (3) @(negedge clock);
        check_disp(255, 6);

        @(negedge clock);
        drive(7);
        repeat (12) @(negedge clock);
        check_disp(7, 6);

        // 100 then 42 two cycles into the conversion.
        @(negedge clock);
        drive(100);
        repeat (3) @(posedge clock);
        @(negedge clock);
        drive(42);
        repeat (6) @(posedge clock);
        #1;
        chk("first_busy", int'(busy_a), 0);
        chk("first_bcd", int'(bcd_a), 12'h100);
        @(posedge clock);
        #1 chk("second_start", int'(busy_a), 1);
        repeat (12) @(negedge clock);
        check_disp(42, 3);

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            drive(i);
            repeat (10) @(negedge clock);
            chk("sweep_bcd", int'(bcd_a), int'(to_bcd(i)));
            check_disp(i, 1);
        end

        // Random values and hold times.
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 255));
            @(negedge clock);
            drive(v);
            repeat ($urandom_range(10, 14)) @(negedge clock);
            check_disp(v, 3);
        end

        repeat (12) @(negedge clock);
        chk("queue_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
